// File: rtl/fetch_decode_reg.sv
// ---------------------------------------------------------------------------
// fetch_decode_reg
//   F/D pipeline latch with stall / flush / halt control and a saturating
//   hazard-stall cycle counter.
//
// Ports
//   clk, rst_n       : clock (rising edge), asynchronous active-low reset
//   instr_in         : instruction from fetch memory
//   pc_plus2_in      : PC+2 of instr_in
//   fetch_valid      : instr_in valid this cycle (0 = memory not ready)
//   stall            : decode hazard stall for the instruction in instr_out
//   flush            : execute-stage redirect, F/D contents are wrong-path
//   instr_out        : decode-stage instruction
//   pc_plus2_out     : decode-stage PC+2
//   valid_out        : instr_out is a real instruction
//   pc_write_en      : PC register may load (combinational)
//   bubble_dx        : D/X latch loads a NOP this edge (combinational)
//   halted           : FSM is in HALT (registered)
//   stall_cycles     : saturating count of hazard-stall cycles
// ---------------------------------------------------------------------------
module fetch_decode_reg #(
    parameter logic [15:0] NOP_INSTR = 16'h0800,
    parameter logic [4:0]  HALT_OP   = 5'b00000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr_in,
    input  logic [15:0] pc_plus2_in,
    input  logic        fetch_valid,
    input  logic        stall,
    input  logic        flush,
    output logic [15:0] instr_out,
    output logic [15:0] pc_plus2_out,
    output logic        valid_out,
    output logic        pc_write_en,
    output logic        bubble_dx,
    output logic        halted,
    output logic [15:0] stall_cycles
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic        halted_q;
    logic [15:0] cnt_q, cnt_d;
    logic        is_halt_op;

    assign is_halt_op = (instr_in[15:11] == HALT_OP);

    // F/D next-state, highest priority first. A stall holds even when fetch
    // memory is not ready so the stalled instruction is never overwritten.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (flush) begin
            instr_d = NOP_INSTR;
            pc_d    = 16'h0000;
            valid_d = 1'b0;
            state_d = ST_RUN;
        end else if (state_q == ST_HALT) begin
            // hold everything until a redirect
        end else if (stall) begin
            // hold for the hazard
        end else if (!fetch_valid) begin
            // bubble, keep the last PC+2 for debug visibility
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else begin
            instr_d = instr_in;
            pc_d    = pc_plus2_in;
            valid_d = 1'b1;
            if (is_halt_op) state_d = ST_HALT;
        end

        cnt_d = cnt_q;
        if (state_q == ST_RUN && stall && !flush && cnt_q != 16'hFFFF)
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            instr_q  <= NOP_INSTR;
            pc_q     <= 16'h0000;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            cnt_q    <= 16'h0000;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            halted_q <= (state_d == ST_HALT);
            cnt_q    <= cnt_d;
        end
    end

    // Not advancing on the HALT fetch parks the PC on the HALT address.
    assign pc_write_en  = flush |
                          (state_q == ST_RUN && !stall && fetch_valid && !is_halt_op);
    assign bubble_dx    = flush | stall | !valid_q | halted_q;

    assign instr_out    = instr_q;
    assign pc_plus2_out = pc_q;
    assign valid_out    = valid_q;
    assign halted       = halted_q;
    assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_fetch_decode_reg.sv
module tb_fetch_decode_reg;

    localparam logic [15:0] NOP = 16'h0800;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] instr_in = '0;
    logic [15:0] pc_plus2_in = '0;
    logic        fetch_valid = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] instr_out, pc_plus2_out, stall_cycles;
    logic        valid_out, pc_write_en, bubble_dx, halted;

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural reference state
    logic [15:0] m_instr, m_pc, m_cnt;
    logic        m_valid, m_halt;

    fetch_decode_reg dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_in     (instr_in),
        .pc_plus2_in  (pc_plus2_in),
        .fetch_valid  (fetch_valid),
        .stall        (stall),
        .flush        (flush),
        .instr_out    (instr_out),
        .pc_plus2_out (pc_plus2_out),
        .valid_out    (valid_out),
        .pc_write_en  (pc_write_en),
        .bubble_dx    (bubble_dx),
        .halted       (halted),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_instr = NOP; m_pc = 16'h0; m_valid = 1'b0; m_halt = 1'b0; m_cnt = 16'h0;
    endtask

    // One rising edge of the F/D latch as described by the priority rules.
    task automatic model_edge();
        logic was_halt;
        was_halt = m_halt;
        if (!rst_n) begin
            model_reset();
        end else begin
            if (!was_halt && stall && !flush && m_cnt < 16'hFFFF) m_cnt = m_cnt + 1;
            if (flush) begin
                m_instr = NOP; m_pc = 16'h0; m_valid = 1'b0; m_halt = 1'b0;
            end else if (was_halt || stall) begin
            end else if (!fetch_valid) begin
                m_instr = NOP; m_valid = 1'b0;
            end else begin
                m_instr = instr_in; m_pc = pc_plus2_in; m_valid = 1'b1;
                m_halt = (instr_in[15:11] == 5'b00000);
            end
        end
    endtask

    function automatic logic m_pcwe();
        return flush | (!m_halt && !stall && fetch_valid && instr_in[15:11] != 5'b00000);
    endfunction

    function automatic logic m_bub();
        return flush | stall | !m_valid | m_halt;
    endfunction

    task automatic drive(input logic [15:0] i, input logic [15:0] p,
                         input logic fv, input logic st, input logic fl);
        @(negedge clk);
        instr_in = i; pc_plus2_in = p; fetch_valid = fv; stall = st; flush = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        instr_in = 16'h4021; pc_plus2_in = 16'h0002; fetch_valid = 1'b1;
        stall = 1'b0; flush = 1'b0;
        model_reset();
        #12;
        n_checks++;
        if ({instr_out, pc_plus2_out, valid_out, halted, stall_cycles} !==
            {NOP, 16'h0000, 1'b0, 1'b0, 16'h0000}) begin
            n_fail++;
            $display("FAIL reset_regs: got instr=%h pc=%h v=%b h=%b cnt=%h, want 0800 0000 0 0 0000",
                     instr_out, pc_plus2_out, valid_out, halted, stall_cycles);
        end
        n_checks++;
        if ({bubble_dx, pc_write_en} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_comb: got bubble=%b pcwe=%b, want 1 1", bubble_dx, pc_write_en);
        end
    endtask

    task automatic test_stream();
        @(negedge clk);
        rst_n = 1'b1;
        drive(16'h4021, 16'h0002, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (pc_write_en !== 1'b1) begin
            n_fail++; $display("FAIL stream_pcwe: got %b, want 1", pc_write_en);
        end
        tick();
        n_checks++;
        if ({instr_out, pc_plus2_out, valid_out, bubble_dx, pc_write_en} !==
            {16'h4021, 16'h0002, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL stream_load: got instr=%h pc=%h v=%b bub=%b pcwe=%b, want 4021 0002 1 0 1",
                     instr_out, pc_plus2_out, valid_out, bubble_dx, pc_write_en);
        end
    endtask

    task automatic test_stall();
        drive(16'h8C40, 16'h0004, 1'b1, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(16'h1234, 16'h0006, 1'b1, 1'b1, 1'b0);
            n_checks++;
            if ({pc_write_en, bubble_dx} !== 2'b01) begin
                n_fail++;
                $display("FAIL stall_comb[%0d]: got pcwe=%b bub=%b, want 0 1", k, pc_write_en, bubble_dx);
            end
            tick();
            n_checks++;
            if ({instr_out, pc_plus2_out, valid_out} !== {16'h8C40, 16'h0004, 1'b1}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got instr=%h pc=%h v=%b, want 8c40 0004 1",
                         k, instr_out, pc_plus2_out, valid_out);
            end
        end
        n_checks++;
        if (stall_cycles !== 16'd2) begin
            n_fail++; $display("FAIL stall_count: got %0d, want 2", stall_cycles);
        end
    endtask

    task automatic test_stall_flush();
        drive(16'h1234, 16'h0006, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if ({pc_write_en, bubble_dx} !== 2'b11) begin
            n_fail++;
            $display("FAIL sflush_comb: got pcwe=%b bub=%b, want 1 1", pc_write_en, bubble_dx);
        end
        tick();
        n_checks++;
        if ({instr_out, pc_plus2_out, valid_out, stall_cycles} !==
            {NOP, 16'h0000, 1'b0, 16'd2}) begin
            n_fail++;
            $display("FAIL sflush_regs: got instr=%h pc=%h v=%b cnt=%0d, want 0800 0000 0 2",
                     instr_out, pc_plus2_out, valid_out, stall_cycles);
        end
    endtask

    task automatic test_fetch_gap();
        drive(16'h4444, 16'h0010, 1'b1, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(16'h5555, 16'h0012, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (pc_write_en !== 1'b0) begin
                n_fail++; $display("FAIL gap_pcwe[%0d]: got %b, want 0", k, pc_write_en);
            end
            tick();
            n_checks++;
            if ({instr_out, pc_plus2_out, valid_out, bubble_dx} !== {NOP, 16'h0010, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL gap_bubble[%0d]: got instr=%h pc=%h v=%b bub=%b, want 0800 0010 0 1",
                         k, instr_out, pc_plus2_out, valid_out, bubble_dx);
            end
        end
    endtask

    task automatic test_halt();
        logic [15:0] cnt0;
        cnt0 = stall_cycles;
        drive(16'h0000, 16'h0020, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (pc_write_en !== 1'b0) begin
            n_fail++; $display("FAIL halt_pcwe: got %b, want 0", pc_write_en);
        end
        tick();
        n_checks++;
        if ({halted, instr_out, valid_out} !== {1'b1, 16'h0000, 1'b1}) begin
            n_fail++;
            $display("FAIL halt_enter: got h=%b instr=%h v=%b, want 1 0000 1", halted, instr_out, valid_out);
        end
        for (int k = 0; k < 10; k++) begin
            // a stall while halted must not be counted
            drive(16'h6000 + 16'(k), 16'h0030, 1'b1, k[0], 1'b0);
            n_checks++;
            if ({pc_write_en, bubble_dx} !== 2'b01) begin
                n_fail++;
                $display("FAIL halt_comb[%0d]: got pcwe=%b bub=%b, want 0 1", k, pc_write_en, bubble_dx);
            end
            tick();
            n_checks++;
            if ({halted, instr_out, pc_plus2_out, stall_cycles} !== {1'b1, 16'h0000, 16'h0020, cnt0}) begin
                n_fail++;
                $display("FAIL halt_hold[%0d]: got h=%b instr=%h pc=%h cnt=%h, want 1 0000 0020 %h",
                         k, halted, instr_out, pc_plus2_out, stall_cycles, cnt0);
            end
        end
        drive(16'h6000, 16'h0030, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (pc_write_en !== 1'b1) begin
            n_fail++; $display("FAIL halt_flush_pcwe: got %b, want 1", pc_write_en);
        end
        tick();
        n_checks++;
        if ({halted, instr_out, valid_out} !== {1'b0, NOP, 1'b0}) begin
            n_fail++;
            $display("FAIL halt_exit: got h=%b instr=%h v=%b, want 0 0800 0", halted, instr_out, valid_out);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            logic [15:0] ri;
            ri = 16'($urandom);
            if ($urandom_range(0, 9) == 0) ri[15:11] = 5'b00000;
            drive(ri, 16'($urandom), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0);
            n_checks++;
            if ({pc_write_en, bubble_dx} !== {m_pcwe(), m_bub()}) begin
                n_fail++;
                $display("FAIL rnd_comb[%0d]: got pcwe=%b bub=%b, want %b %b",
                         n, pc_write_en, bubble_dx, m_pcwe(), m_bub());
            end
            if ($urandom_range(0, 199) == 0) begin
                // asynchronous reset well away from any clock edge
                #1 rst_n = 1'b0;
                #1;
                model_reset();
                n_checks++;
                if ({instr_out, pc_plus2_out, valid_out, halted, stall_cycles, bubble_dx} !==
                    {NOP, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1}) begin
                    n_fail++;
                    $display("FAIL rnd_async_reset[%0d]: got instr=%h pc=%h v=%b h=%b cnt=%h bub=%b",
                             n, instr_out, pc_plus2_out, valid_out, halted, stall_cycles, bubble_dx);
                end
                rst_n = 1'b1;
            end
            tick();
            n_checks++;
            if ({instr_out, pc_plus2_out, valid_out, halted, stall_cycles} !==
                {m_instr, m_pc, m_valid, m_halt, m_cnt}) begin
                n_fail++;
                $display("FAIL rnd_regs[%0d]: got %h %h %b %b %h, want %h %h %b %b %h", n,
                         instr_out, pc_plus2_out, valid_out, halted, stall_cycles,
                         m_instr, m_pc, m_valid, m_halt, m_cnt);
            end
        end
    endtask

    task automatic test_saturate();
        @(negedge clk);
        rst_n = 1'b0;
        instr_in = 16'h4021; pc_plus2_in = 16'h0002; fetch_valid = 1'b1;
        stall = 1'b1; flush = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 65540; k++) begin
            tick();
            if (k == 65534) begin
                n_checks++;
                if (stall_cycles !== 16'hFFFE) begin
                    n_fail++; $display("FAIL sat_pre: got %h, want fffe", stall_cycles);
                end
            end
        end
        n_checks++;
        if ({stall_cycles, instr_out, valid_out} !== {16'hFFFF, NOP, 1'b0}) begin
            n_fail++;
            $display("FAIL sat_final: got cnt=%h instr=%h v=%b, want ffff 0800 0",
                     stall_cycles, instr_out, valid_out);
        end
        n_checks++;
        if (m_cnt !== stall_cycles) begin
            n_fail++; $display("FAIL sat_model: got %h, want %h", stall_cycles, m_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_stall_flush();
        test_fetch_gap();
        test_halt();
        test_random();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
